banco_registrador_multi: RTL and testbench

BANCO_REGISTRADOR_MULTI -- requirements
Module: banco_registrador_multi

---
 rtl/banco_registrador_multi.sv | 108 ++++++++++
 tb/tb_banco_registrador_multi.sv | 136 +++++++++++++
 2 files changed

// File: rtl/banco_registrador_multi.sv
// banco_registrador_multi: 3-read/2-write register file with busy scoreboard; BANCO_REGISTRADOR_BYPASS_EN enables write-to-read forwarding
module banco_registrador_multi #(
  parameter int XLEN = 32,
  parameter int AMOUNT = 16,
  parameter int ADDRESSLEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDRESSLEN-1:0] rs1,
  input  logic [ADDRESSLEN-1:0] rs2,
  input  logic [ADDRESSLEN-1:0] rs3,
  output logic [XLEN-1:0]       r1,
  output logic [XLEN-1:0]       r2,
  output logic [XLEN-1:0]       r3,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  busy3,
  input  logic                  wEn0,
  input  logic                  wEn1,
  input  logic [ADDRESSLEN-1:0] rd0,
  input  logic [ADDRESSLEN-1:0] rd1,
  input  logic [XLEN-1:0]       data0,
  input  logic [XLEN-1:0]       data1,
  input  logic                  alloc_en,
  input  logic [ADDRESSLEN-1:0] alloc_rd
);
  logic [XLEN-1:0]   regs   [AMOUNT];
  logic [XLEN-1:0]   regs_n [AMOUNT];
  logic [XLEN-1:0]   rsrc   [AMOUNT];
  logic [AMOUNT-1:0] busy, busy_n, bsrc;
  logic [XLEN-1:0]   rv1, rv2, rv3;
  logic              bv1, bv2, bv3;

  // Entry 0 and addresses >= AMOUNT never match, so x0 stays zero/idle and out-of-range ops drop.
  // Port 1 is applied after port 0 and alloc last, giving data1-wins and alloc-wins.
  always_comb begin
    regs_n = regs;
    busy_n = busy;
    for (int i = 1; i < AMOUNT; i++) begin
      if (wEn0 && rd0 == ADDRESSLEN'(i)) begin
        regs_n[i] = data0;
        busy_n[i] = 1'b0;
      end
      if (wEn1 && rd1 == ADDRESSLEN'(i)) begin
        regs_n[i] = data1;
        busy_n[i] = 1'b0;
      end
      if (alloc_en && alloc_rd == ADDRESSLEN'(i)) busy_n[i] = 1'b1;
    end
  end

`ifdef BANCO_REGISTRADOR_BYPASS_EN
  always_comb begin
    rsrc = regs_n;
    bsrc = busy_n;
  end
`else
  always_comb begin
    rsrc = regs;
    bsrc = busy;
  end
`endif

  always_comb begin
    rv1 = '0;
    rv2 = '0;
    rv3 = '0;
    bv1 = 1'b0;
    bv2 = 1'b0;
    bv3 = 1'b0;
    for (int i = 0; i < AMOUNT; i++) begin
      if (rs1 == ADDRESSLEN'(i)) begin
        rv1 = rsrc[i];
        bv1 = bsrc[i];
      end
      if (rs2 == ADDRESSLEN'(i)) begin
        rv2 = rsrc[i];
        bv2 = bsrc[i];
      end
      if (rs3 == ADDRESSLEN'(i)) begin
        rv3 = rsrc[i];
        bv3 = bsrc[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < AMOUNT; i++) regs[i] <= '0;
      busy  <= '0;
      r1    <= '0;
      r2    <= '0;
      r3    <= '0;
      busy1 <= 1'b0;
      busy2 <= 1'b0;
      busy3 <= 1'b0;
    end else begin
      regs  <= regs_n;
      busy  <= busy_n;
      r1    <= rv1;
      r2    <= rv2;
      r3    <= rv3;
      busy1 <= bv1;
      busy2 <= bv2;
      busy3 <= bv3;
    end
  end
endmodule

// File: tb/tb_banco_registrador_multi.sv
// tb_banco_registrador_multi: directed + random check of banco_registrador_multi against an array model
module tb_banco_registrador_multi;
  localparam int AMT = 12;
  logic clk = 0, reset = 0;
  logic [3:0] rs1 = 0, rs2 = 0, rs3 = 0, rd0 = 0, rd1 = 0, alloc_rd = 0;
  logic [31:0] r1, r2, r3, data0 = 0, data1 = 0;
  logic busy1, busy2, busy3, wEn0 = 0, wEn1 = 0, alloc_en = 0;
  logic [31:0] m_reg [16];
  logic m_busy [16];
  logic [31:0] e_r [3];
  logic e_b [3];
  int n_checks = 0, n_fail = 0;
`ifdef BANCO_REGISTRADOR_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif

  banco_registrador_multi #(.XLEN(32), .AMOUNT(AMT), .ADDRESSLEN(4)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .r1(r1), .r2(r2), .r3(r3), .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .wEn0(wEn0), .wEn1(wEn1), .rd0(rd0), .rd1(rd1), .data0(data0), .data1(data1),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ok(input logic [3:0] a);
    return a != 0 && int'(a) < AMT;
  endfunction

  task automatic idle();
    reset = 1; wEn0 = 0; wEn1 = 0; alloc_en = 0;
    rd0 = 0; rd1 = 0; alloc_rd = 0; data0 = 0; data1 = 0;
    rs1 = 0; rs2 = 0; rs3 = 0;
  endtask

  // Advance one edge, update the model from the pre-edge inputs, compare all outputs.
  task automatic step();
    logic [31:0] nr [16];
    logic nb [16];
    logic [3:0] rs [3];
    @(posedge clk);
    rs[0] = rs1; rs[1] = rs2; rs[2] = rs3;
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
      for (int k = 0; k < 3; k++) begin e_r[k] = 0; e_b[k] = 0; end
    end else begin
      nr = m_reg; nb = m_busy;
      if (wEn0 && ok(rd0)) begin nr[rd0] = data0; nb[rd0] = 0; end
      if (wEn1 && ok(rd1)) begin nr[rd1] = data1; nb[rd1] = 0; end
      if (alloc_en && ok(alloc_rd)) nb[alloc_rd] = 1;
      for (int k = 0; k < 3; k++) begin
        e_r[k] = ok(rs[k]) ? (BYP ? nr[rs[k]] : m_reg[rs[k]]) : 0;
        e_b[k] = ok(rs[k]) ? (BYP ? nb[rs[k]] : m_busy[rs[k]]) : 0;
      end
      m_reg = nr; m_busy = nb;
    end
    #1;
    check("r1", r1, e_r[0]);
    check("r2", r2, e_r[1]);
    check("r3", r3, e_r[2]);
    check("busy1", {31'b0, busy1}, {31'b0, e_b[0]});
    check("busy2", {31'b0, busy2}, {31'b0, e_b[1]});
    check("busy3", {31'b0, busy3}, {31'b0, e_b[2]});
  endtask

  initial begin
    idle(); reset = 0;
    step(); step();
    check("rst_r1", r1, 0);
    check("rst_busy1", {31'b0, busy1}, 0);
    // x0 ignores writes
    idle(); wEn0 = 1; rd0 = 0; data0 = 32'hDEADBEEF; step();
    idle(); rs1 = 0; step();
    check("x0_r1", r1, 0);
    check("x0_busy1", {31'b0, busy1}, 0);
    // dual write to the same register: port 1 wins
    idle(); wEn0 = 1; wEn1 = 1; rd0 = 5; rd1 = 5; data0 = 32'h11; data1 = 32'h22; step();
    idle(); rs2 = 5; step();
    check("dual_r2", r2, 32'h22);
    // scoreboard set by alloc, cleared by write
    idle(); alloc_en = 1; alloc_rd = 7; step();
    idle(); rs3 = 7; step();
    check("alloc_busy3", {31'b0, busy3}, 1);
    idle(); wEn0 = 1; rd0 = 7; data0 = 32'h77; rs3 = 7; step();
    check("wr_same_busy3", {31'b0, busy3}, BYP ? 0 : 1);
    idle(); rs3 = 7; step();
    check("clr_busy3", {31'b0, busy3}, 0);
    check("clr_r3", r3, 32'h77);
    // alloc and write collide: data lands, busy stays set
    idle(); alloc_en = 1; alloc_rd = 3; wEn1 = 1; rd1 = 3; data1 = 32'h55; step();
    idle(); rs1 = 3; step();
    check("coll_r1", r1, 32'h55);
    check("coll_busy1", {31'b0, busy1}, 1);
    // forwarding
    idle(); wEn0 = 1; rd0 = 9; data0 = 32'hA; step();
    idle(); wEn0 = 1; rd0 = 9; data0 = 32'hB; rs1 = 9; step();
    check("fwd_r1", r1, BYP ? 32'hB : 32'hA);
    // out-of-range addresses
    idle(); wEn0 = 1; rd0 = 13; data0 = 32'h1313; alloc_en = 1; alloc_rd = 14; step();
    idle(); rs1 = 13; rs2 = 14; step();
    check("oor_r1", r1, 0);
    check("oor_busy2", {31'b0, busy2}, 0);
    // reset beats a same-cycle write and alloc
    idle(); alloc_en = 1; alloc_rd = 6; step();
    idle(); reset = 0; wEn0 = 1; rd0 = 4; data0 = 32'h99; alloc_en = 1; alloc_rd = 6; step();
    idle(); rs1 = 4; rs2 = 6; rs3 = 3; step();
    check("mid_rst_r1", r1, 0);
    check("mid_rst_busy1", {31'b0, busy1}, 0);
    check("mid_rst_busy2", {31'b0, busy2}, 0);
    check("mid_rst_busy3", {31'b0, busy3}, 0);
    // random traffic
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) >= 3);
      wEn0 = $urandom_range(0, 1); wEn1 = $urandom_range(0, 1); alloc_en = $urandom_range(0, 1);
      rd0 = 4'($urandom); rd1 = ($urandom_range(0, 3) == 0) ? rd0 : 4'($urandom);
      alloc_rd = ($urandom_range(0, 3) == 0) ? rd1 : 4'($urandom);
      data0 = $urandom; data1 = $urandom;
      rs1 = ($urandom_range(0, 2) == 0) ? rd0 : 4'($urandom);
      rs2 = ($urandom_range(0, 2) == 0) ? rd1 : 4'($urandom);
      rs3 = ($urandom_range(0, 2) == 0) ? alloc_rd : 4'($urandom);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
